nfa_stream_interfacer: RTL
==========================

// Module: nfa_stream_interfacer
// PURPOSE
//   Parametrised front-end between the byte-stream source and the NFA match array.
//   Pipelines {valid,data} by PIPE_DEPTH cycles and frames each stream with sod/eod.
//   Drives the array enable and holds stop for FLUSH_CYCLES after eod so in-flight matches drain.
//   Adds frame-length counting and protocol-error detection.
// PARAMETERS
//   DATA_W        8   width of in_data/out_data
//   PIPE_DEPTH    2   pipeline stages from in_* to out_* (>=1)
//   FLUSH_CYCLES  3   cycles stop stays high after eod (>=1)
//   CNT_W         16  width of frame_len (saturating)
// PORTS
//   clk        in   1       single clock, all state on posedge
//   rst_n      in   1       asynchronous active-low reset
//   sod        in   1       start-of-data strobe, one cycle
//   eod        in   1       end-of-data strobe, one cycle
//   in_valid   in   1       in_data carries a stream symbol this cycle
//   in_data    in   DATA_W  stream symbol
//   out_data   out  DATA_W  in_data delayed PIPE_DEPTH cycles
//   out_en     out  1       NFA array enable
//   stop       out  1       flush window active (state FLUSH)
//   busy       out  1       state != IDLE
//   frame_len  out  CNT_W   valid symbols accepted in current/last frame
//   proto_err  out  1       one-cycle pulse on framing violation
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, pipeline cleared, all outputs 0, frame_len=0.
//   FSM states IDLE, ACTIVE, FLUSH; flush counter fcnt.
//     IDLE:   sod&!eod -> ACTIVE; sod&eod -> FLUSH (one-symbol frame); eod alone -> proto_err, stay.
//     ACTIVE: eod -> FLUSH, fcnt=0; sod -> proto_err, frame restarts (frame_len cleared), stay.
//             sod&eod together -> proto_err, then FLUSH.
//     FLUSH:  fcnt increments each cycle; fcnt==FLUSH_CYCLES-1 -> IDLE.
//             sod -> abort flush, ACTIVE, no error; eod -> proto_err, ignored.
//   stop = (state==FLUSH); registered; high exactly FLUSH_CYCLES cycles, starting the cycle after eod.
//   Accept: in_valid is accepted when state==ACTIVE, or on sod cycle; otherwise treated as 0.
//   Pipeline: PIPE_DEPTH registers of {accepted_valid,in_data}; out_data = last stage data.
//     out_data is updated every cycle regardless of valid.
//   Warm-up: sod shifted through a PIPE_DEPTH-deep 1-bit chain -> sod_d.
//   out_en = last-stage valid | sod_d | stop (combinational OR of registered terms).
//   frame_len: cleared on accepted sod; +1 per accepted valid; saturates at 2^CNT_W-1.
//     Holds after eod until next sod.
//   proto_err: registered, asserted the cycle after the violating input, deasserted next cycle.
//   Reset mid-frame: immediate return to IDLE, pipeline contents discarded, no proto_err.
// STRUCTURE
//   Shared package nfa_if_pkg: state encoding localparams (IDLE=2'd0, ACTIVE=2'd1, FLUSH=2'd2).
//   One sub-module: nfa_pipe_reg #(W,DEPTH) — generic async-reset shift pipeline.
//     Used for {valid,data} and for the sod chain.
//   FSM, flush counter, frame counter and error logic stay in this module.
// TESTING
//   T1 defaults: sod@c0 with 5 valid bytes 0x41..0x45 c0-c4, eod@c4.
//      -> out_data 0x41..0x45 at c2-c6; stop high c5-c7; busy low c8; frame_len=5.
//   T2 sod&eod same cycle in IDLE, in_valid=1, data 0x7F.
//      -> 0x7F out 2 cycles later with out_en; stop 3 cycles; frame_len=1; no proto_err.
//   T3 sod during FLUSH (2nd stop cycle).
//      -> stop drops next cycle, state ACTIVE, frame_len=0, proto_err stays 0.
//   T4 sod during ACTIVE; separately, eod in IDLE.
//      -> proto_err one-cycle pulse each case; frame_len cleared only for sod.
//   T5 CNT_W=4, 20 valid bytes in one frame -> frame_len saturates at 15.
//      T5 also runs PIPE_DEPTH=4, FLUSH_CYCLES=1 -> 4-cycle latency, stop exactly 1 cycle.
//   T6 rst_n low mid-ACTIVE with pipeline full.
//      -> all outputs 0 asynchronously; the first valid after the next sod emerges at PIPE_DEPTH latency.

Source files
------------

// File: rtl/nfa_if_pkg.sv
// rtl/nfa_if_pkg.sv - shared state encoding for the NFA stream front-end
//
// Purpose: state encoding shared by nfa_stream_interfacer and anything that
//          needs to decode its state.
// Ports:   none (package).
package nfa_if_pkg;

   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
   localparam logic [STATE_W-1:0] ST_ACTIVE = 2'd1;
   localparam logic [STATE_W-1:0] ST_FLUSH  = 2'd2;

endpackage

// File: rtl/nfa_pipe_reg.sv
// rtl/nfa_pipe_reg.sv - generic async-reset shift pipeline
//
// Purpose: delays d_i by DEPTH clock cycles. Every stage clears on reset.
// Ports:
//   clk    in   1   clock
//   rst_n  in   1   asynchronous active-low reset
//   d_i    in   W   pipeline input
//   q_o    out  W   d_i delayed DEPTH cycles
module nfa_pipe_reg #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] stage_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/nfa_stream_interfacer.sv
// rtl/nfa_stream_interfacer.sv - framing front-end between byte stream and NFA array
//
// Purpose: pipelines {valid,data} by PIPE_DEPTH cycles, frames each stream with
//          sod/eod, drives the array enable, holds stop for FLUSH_CYCLES after
//          eod, counts accepted symbols and flags framing violations.
// Ports:
//   clk        in   1       clock
//   rst_n      in   1       asynchronous active-low reset
//   sod        in   1       start-of-data strobe
//   eod        in   1       end-of-data strobe
//   in_valid   in   1       in_data carries a symbol
//   in_data    in   DATA_W  stream symbol
//   out_data   out  DATA_W  in_data delayed PIPE_DEPTH cycles
//   out_en     out  1       NFA array enable
//   stop       out  1       flush window active
//   busy       out  1       not idle
//   frame_len  out  CNT_W   accepted symbols in current/last frame (saturating)
//   proto_err  out  1       one-cycle framing-violation pulse
module nfa_stream_interfacer
   import nfa_if_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int PIPE_DEPTH   = 2,
   parameter int FLUSH_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sod,
   input  logic              eod,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_en,
   output logic              stop,
   output logic              busy,
   output logic [CNT_W-1:0]  frame_len,
   output logic              proto_err
);

   localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FLUSH_CYCLES - 1);

   logic [STATE_W-1:0] state_q, state_d;
   logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
   logic [CNT_W-1:0]   len_q, len_d;
   logic               err_q, err_d;

   logic               acc_valid;
   logic [DATA_W:0]    pipe_out;
   logic               sod_dly;

   // A symbol is only taken inside a frame or on the sod that opens one.
   assign acc_valid = in_valid & ((state_q == ST_ACTIVE) | sod);

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sod) begin
               state_d = eod ? ST_FLUSH : ST_ACTIVE;
               fcnt_d  = '0;
            end else if (eod) begin
               err_d = 1'b1;
            end
         end
         ST_ACTIVE: begin
            // sod inside a frame restarts it; combined with eod it also closes it.
            fcnt_d = '0;
            if (sod) begin
               err_d = 1'b1;
            end
            if (eod) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            // A new sod cuts the drain short and starts a fresh frame.
            if (sod) begin
               state_d = eod ? ST_FLUSH : ST_ACTIVE;
               fcnt_d  = '0;
            end else begin
               if (eod) begin
                  err_d = 1'b1;
               end
               if (fcnt_q == FCNT_LAST) begin
                  state_d = ST_IDLE;
                  fcnt_d  = '0;
               end else begin
                  fcnt_d = fcnt_q + FCNT_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            fcnt_d  = '0;
         end
      endcase
   end

   always_comb begin
      len_d = len_q;
      if (sod) begin
         len_d = acc_valid ? CNT_W'(1) : '0;
      end else if (acc_valid && (len_q != {CNT_W{1'b1}})) begin
         len_d = len_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         fcnt_q  <= '0;
         len_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         len_q   <= len_d;
         err_q   <= err_d;
      end
   end

   nfa_pipe_reg #(
      .W     (DATA_W + 1),
      .DEPTH (PIPE_DEPTH)
   ) u_data_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   ({acc_valid, in_data}),
      .q_o   (pipe_out)
   );

   // sod travels alongside the data so the array is enabled for the warm-up
   // cycle even when the opening symbol was not valid.
   nfa_pipe_reg #(
      .W     (1),
      .DEPTH (PIPE_DEPTH)
   ) u_sod_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (sod),
      .q_o   (sod_dly)
   );

   assign stop      = (state_q == ST_FLUSH);
   assign busy      = (state_q != ST_IDLE);
   assign out_data  = pipe_out[DATA_W-1:0];
   assign out_en    = pipe_out[DATA_W] | sod_dly | stop;
   assign frame_len = len_q;
   assign proto_err = err_q;

endmodule
